// File: rtl/msrv32_machine_control_if.sv
// Bus between the MSRV32 decoder/CSR side and the machine-control sequencer.
// The master modport is the core side that supplies decode flags,
// instruction fields and interrupt lines. The slave modport is the
// sequencer that answers with trap/return control.
interface msrv32_machine_control_if;
    // decoder exception flags
    logic       illegal_instr_in;
    logic       misaligned_load_in;
    logic       misaligned_store_in;
    logic       misaligned_instr_in;
    // SYSTEM instruction fields
    logic [4:0] opcode_6_to_2_in;
    logic [2:0] funct3_in;
    logic [6:0] funct7_in;
    logic [4:0] rs1_addr_in;
    logic [4:0] rs2_addr_in;
    logic [4:0] rd_addr_in;
    // interrupt enables and requests
    logic       mie_in;
    logic       meie_in;
    logic       mtie_in;
    logic       msie_in;
    logic       e_irq_in;
    logic       t_irq_in;
    logic       s_irq_in;
    // sequencer outputs
    logic       trap_taken_out;
    logic       i_or_e_out;
    logic [3:0] cause_out;
    logic       set_cause_out;
    logic       set_epc_out;
    logic       mie_clear_out;
    logic       mie_set_out;
    logic       instret_inc_out;
    logic       misaligned_exception_out;
    logic [1:0] pc_src_out;
    logic       flush_out;

    modport master (
        output illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in,
        output opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
        output mie_in, meie_in, mtie_in, msie_in, e_irq_in, t_irq_in, s_irq_in,
        input  trap_taken_out, i_or_e_out, cause_out, set_cause_out, set_epc_out,
        input  mie_clear_out, mie_set_out, instret_inc_out, misaligned_exception_out,
        input  pc_src_out, flush_out
    );

    modport slave (
        input  illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in,
        input  opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
        input  mie_in, meie_in, mtie_in, msie_in, e_irq_in, t_irq_in, s_irq_in,
        output trap_taken_out, i_or_e_out, cause_out, set_cause_out, set_epc_out,
        output mie_clear_out, mie_set_out, instret_inc_out, misaligned_exception_out,
        output pc_src_out, flush_out
    );
endinterface

// File: rtl/msrv32_machine_control.sv
// MSRV32 machine-mode trap and return sequencer.
// Detects exceptions, interrupts and mret in the OPERATING state, flags the
// trap combinationally to the decoder, then spends one cycle in TRAP_TAKEN
// or TRAP_RETURN issuing CSR strobes, flush and PC source selection.
// Optional feature macro: MSRV32_IRQ_EN (interrupt detection and the
// interrupt cause path). Without it, irq is constant 0 and i_or_e_out is 0.
module msrv32_machine_control (
    input logic                      clk_in,
    input logic                      rst_in,
    msrv32_machine_control_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RESET       = 2'b00,
        ST_OPERATING   = 2'b01,
        ST_TRAP_TAKEN  = 2'b10,
        ST_TRAP_RETURN = 2'b11
    } state_t;

    state_t     state;
    state_t     next_state;

    logic       is_system;
    logic       ecall;
    logic       ebreak;
    logic       mret;
    logic       exc;
    logic       irq;
    logic [3:0] exc_cause;
    logic [3:0] irq_cause;
    logic [3:0] cause_q;
    logic       i_or_e_q;
    logic       trap_req;

    // SYSTEM decode: only the rs1 = rd = 0, funct3 = 000 forms are privileged ops
    assign is_system = (bus.opcode_6_to_2_in == 5'b11100) && (bus.funct3_in == 3'b000) &&
                       (bus.rs1_addr_in == 5'd0) && (bus.rd_addr_in == 5'd0);
    assign ecall  = is_system && (bus.funct7_in == 7'b0000000) && (bus.rs2_addr_in == 5'b00000);
    assign ebreak = is_system && (bus.funct7_in == 7'b0000000) && (bus.rs2_addr_in == 5'b00001);
    assign mret   = is_system && (bus.funct7_in == 7'b0011000) && (bus.rs2_addr_in == 5'b00010);

    assign exc = bus.misaligned_instr_in | bus.illegal_instr_in | ebreak |
                 bus.misaligned_load_in | bus.misaligned_store_in | ecall;

`ifdef MSRV32_IRQ_EN
    assign irq = bus.mie_in & ((bus.meie_in & bus.e_irq_in) |
                               (bus.mtie_in & bus.t_irq_in) |
                               (bus.msie_in & bus.s_irq_in));

    // Interrupt cause priority: external, then software, then timer
    always_comb begin
        irq_cause = 4'd7;
        if (bus.meie_in && bus.e_irq_in)
            irq_cause = 4'd11;
        else if (bus.msie_in && bus.s_irq_in)
            irq_cause = 4'd3;
    end
`else
    // Interrupt inputs stay on the port list but have no effect in this build
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{bus.mie_in, bus.meie_in, bus.mtie_in, bus.msie_in,
                                 bus.e_irq_in, bus.t_irq_in, bus.s_irq_in};
    assign irq       = 1'b0;
    assign irq_cause = 4'd0;
`endif

    assign trap_req = exc | irq;

    // Exception cause priority, highest first
    always_comb begin
        exc_cause = 4'd11;
        if (bus.misaligned_instr_in)
            exc_cause = 4'd0;
        else if (bus.illegal_instr_in)
            exc_cause = 4'd2;
        else if (ebreak)
            exc_cause = 4'd3;
        else if (bus.misaligned_load_in)
            exc_cause = 4'd4;
        else if (bus.misaligned_store_in)
            exc_cause = 4'd6;
    end

    // State register; reset overrides every state
    always_ff @(posedge clk_in) begin
        if (rst_in)
            state <= ST_RESET;
        else
            state <= next_state;
    end

    // Next-state logic; trap and return states last exactly one cycle
    always_comb begin
        next_state = state;
        case (state)
            ST_RESET:       next_state = ST_OPERATING;
            ST_OPERATING: begin
                if (trap_req)
                    next_state = ST_TRAP_TAKEN;
                else if (mret)
                    next_state = ST_TRAP_RETURN;
            end
            ST_TRAP_TAKEN:  next_state = ST_OPERATING;
            ST_TRAP_RETURN: next_state = ST_OPERATING;
            default:        next_state = ST_RESET;
        endcase
    end

    // Cause capture on trap entry; exceptions take precedence over interrupts
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cause_q  <= 4'd0;
            i_or_e_q <= 1'b0;
        end else if (state == ST_OPERATING && trap_req) begin
            cause_q  <= exc ? exc_cause : irq_cause;
            i_or_e_q <= ~exc;
        end
    end

    assign bus.cause_out  = cause_q;
`ifdef MSRV32_IRQ_EN
    assign bus.i_or_e_out = i_or_e_q;
`else
    assign bus.i_or_e_out = 1'b0;
    logic unused_i_or_e;
    assign unused_i_or_e = i_or_e_q;
`endif

    // Per-state outputs; OPERATING also reflects the live decode
    always_comb begin
        bus.trap_taken_out           = 1'b0;
        bus.set_cause_out            = 1'b0;
        bus.set_epc_out              = 1'b0;
        bus.mie_clear_out            = 1'b0;
        bus.mie_set_out              = 1'b0;
        bus.instret_inc_out          = 1'b0;
        bus.misaligned_exception_out = 1'b0;
        bus.pc_src_out               = 2'b00;
        bus.flush_out                = 1'b0;
        case (state)
            ST_RESET: begin
                bus.pc_src_out = 2'b00;
                bus.flush_out  = 1'b1;
            end
            ST_OPERATING: begin
                bus.pc_src_out               = 2'b11;
                bus.trap_taken_out           = trap_req;
                bus.instret_inc_out          = ~(trap_req | mret);
                bus.misaligned_exception_out = bus.misaligned_instr_in |
                                               bus.misaligned_load_in |
                                               bus.misaligned_store_in;
            end
            ST_TRAP_TAKEN: begin
                bus.pc_src_out    = 2'b10;
                bus.flush_out     = 1'b1;
                bus.set_cause_out = 1'b1;
                bus.set_epc_out   = 1'b1;
                bus.mie_clear_out = 1'b1;
            end
            ST_TRAP_RETURN: begin
                bus.pc_src_out  = 2'b01;
                bus.flush_out   = 1'b1;
                bus.mie_set_out = 1'b1;
            end
            default: begin
                bus.pc_src_out = 2'b00;
                bus.flush_out  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Scoreboard bench for msrv32_machine_control: each stimulus cycle pushes
// the hand-computed output vector; a negedge monitor pops and compares.
module tb_msrv32_machine_control;

    typedef struct packed {
        logic       trap;
        logic       ioe;
        logic [3:0] cause;
        logic       set_cause;
        logic       set_epc;
        logic       mie_clear;
        logic       mie_set;
        logic       instret;
        logic       mis;
        logic [1:0] pc_src;
        logic       flush;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    exp_t  exp_q[$];
    string name_q[$];

    msrv32_machine_control_if bus();

    msrv32_machine_control dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t op_e(logic trap, logic inst, logic mis, logic [3:0] c, logic ioe);
        exp_t e;
        e = '0;
        e.trap = trap; e.instret = inst; e.mis = mis; e.cause = c; e.ioe = ioe;
        e.pc_src = 2'b11;
        return e;
    endfunction

    function automatic exp_t tt_e(logic [3:0] c, logic ioe);
        exp_t e;
        e = '0;
        e.cause = c; e.ioe = ioe; e.pc_src = 2'b10; e.flush = 1'b1;
        e.set_cause = 1'b1; e.set_epc = 1'b1; e.mie_clear = 1'b1;
        return e;
    endfunction

    function automatic exp_t rt_e(logic [3:0] c, logic ioe);
        exp_t e;
        e = '0;
        e.cause = c; e.ioe = ioe; e.pc_src = 2'b01; e.flush = 1'b1; e.mie_set = 1'b1;
        return e;
    endfunction

    function automatic exp_t rs_e();
        exp_t e;
        e = '0;
        e.pc_src = 2'b00; e.flush = 1'b1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.illegal_instr_in    = 1'b0;
        bus.misaligned_load_in  = 1'b0;
        bus.misaligned_store_in = 1'b0;
        bus.misaligned_instr_in = 1'b0;
        bus.opcode_6_to_2_in    = 5'b01100;
        bus.funct3_in           = 3'd0;
        bus.funct7_in           = 7'd0;
        bus.rs1_addr_in         = 5'd0;
        bus.rs2_addr_in         = 5'd0;
        bus.rd_addr_in          = 5'd0;
        bus.mie_in              = 1'b0;
        bus.meie_in             = 1'b0;
        bus.mtie_in             = 1'b0;
        bus.msie_in             = 1'b0;
        bus.e_irq_in            = 1'b0;
        bus.t_irq_in            = 1'b0;
        bus.s_irq_in            = 1'b0;
    endtask

    task automatic sys(input logic [6:0] f7, input logic [4:0] rs2);
        bus.opcode_6_to_2_in = 5'b11100;
        bus.funct7_in        = f7;
        bus.rs2_addr_in      = rs2;
    endtask

    task automatic expect_out(input string n, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // Monitor: compare observed outputs against the next queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a.trap      = bus.trap_taken_out;
            a.ioe       = bus.i_or_e_out;
            a.cause     = bus.cause_out;
            a.set_cause = bus.set_cause_out;
            a.set_epc   = bus.set_epc_out;
            a.mie_clear = bus.mie_clear_out;
            a.mie_set   = bus.mie_set_out;
            a.instret   = bus.instret_inc_out;
            a.mis       = bus.misaligned_exception_out;
            a.pc_src    = bus.pc_src_out;
            a.flush     = bus.flush_out;
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got trap=%b ioe=%b cause=%0d sc=%b se=%b mc=%b ms=%b inst=%b mis=%b pc=%b fl=%b expected trap=%b ioe=%b cause=%0d sc=%b se=%b mc=%b ms=%b inst=%b mis=%b pc=%b fl=%b",
                         n, a.trap, a.ioe, a.cause, a.set_cause, a.set_epc, a.mie_clear, a.mie_set,
                         a.instret, a.mis, a.pc_src, a.flush,
                         e.trap, e.ioe, e.cause, e.set_cause, e.set_epc, e.mie_clear, e.mie_set,
                         e.instret, e.mis, e.pc_src, e.flush);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] c_after_irq;
        logic       ioe_after_irq;
        clr();
        rst = 1'b1;

        // reset held three cycles, then released
        for (int i = 0; i < 3; i++) begin
            tick(); expect_out("reset_hold", rs_e());
        end
        tick(); rst = 1'b0; expect_out("reset_last", rs_e());
        tick(); expect_out("first_operating", op_e(0, 1, 0, 4'd0, 0));

        // illegal instruction
        tick(); clr(); bus.illegal_instr_in = 1'b1;
        expect_out("illegal_detect", op_e(1, 0, 0, 4'd0, 0));
        tick(); clr(); expect_out("illegal_trap", tt_e(4'd2, 0));
        tick(); expect_out("illegal_after", op_e(0, 1, 0, 4'd2, 0));

        // misaligned load + store + ecall together, then back-to-back store fault
        tick(); clr(); bus.misaligned_load_in = 1'b1; bus.misaligned_store_in = 1'b1; sys(7'd0, 5'd0);
        expect_out("multi_detect", op_e(1, 0, 1, 4'd2, 0));
        tick(); clr(); expect_out("multi_trap", tt_e(4'd4, 0));
        tick(); clr(); bus.misaligned_store_in = 1'b1;
        expect_out("b2b_detect", op_e(1, 0, 1, 4'd4, 0));
        tick(); clr(); expect_out("b2b_trap", tt_e(4'd6, 0));
        tick(); expect_out("b2b_after", op_e(0, 1, 0, 4'd6, 0));

        // ebreak
        tick(); clr(); sys(7'd0, 5'd1);
        expect_out("ebreak_detect", op_e(1, 0, 0, 4'd6, 0));
        tick(); clr(); expect_out("ebreak_trap", tt_e(4'd3, 0));
        tick(); expect_out("ebreak_after", op_e(0, 1, 0, 4'd3, 0));

        // misaligned fetch outranks illegal
        tick(); clr(); bus.misaligned_instr_in = 1'b1; bus.illegal_instr_in = 1'b1;
        expect_out("mins_detect", op_e(1, 0, 1, 4'd3, 0));
        tick(); clr(); expect_out("mins_trap", tt_e(4'd0, 0));
        tick(); expect_out("mins_after", op_e(0, 1, 0, 4'd0, 0));

        // mret
        tick(); clr(); sys(7'b0011000, 5'd2);
        expect_out("mret_detect", op_e(0, 0, 0, 4'd0, 0));
        tick(); clr(); expect_out("mret_return", rt_e(4'd0, 0));
        tick(); expect_out("mret_after", op_e(0, 1, 0, 4'd0, 0));

        // mret with a concurrent load fault: the trap wins
        tick(); clr(); sys(7'b0011000, 5'd2); bus.misaligned_load_in = 1'b1;
        expect_out("mret_exc_detect", op_e(1, 0, 1, 4'd0, 0));
        tick(); clr(); expect_out("mret_exc_trap", tt_e(4'd4, 0));
        tick(); expect_out("mret_exc_after", op_e(0, 1, 0, 4'd4, 0));

        // ecall-like encoding with rs1 != 0 is not a SYSTEM op
        tick(); clr(); sys(7'd0, 5'd0); bus.rs1_addr_in = 5'd1;
        expect_out("not_ecall", op_e(0, 1, 0, 4'd4, 0));

        // timer + external interrupt: external wins
        tick(); clr(); bus.mie_in = 1'b1; bus.mtie_in = 1'b1; bus.t_irq_in = 1'b1;
        bus.meie_in = 1'b1; bus.e_irq_in = 1'b1;
`ifdef MSRV32_IRQ_EN
        expect_out("irq_te_detect", op_e(1, 0, 0, 4'd4, 0));
        tick(); clr(); expect_out("irq_te_trap", tt_e(4'd11, 1));
        tick(); expect_out("irq_te_after", op_e(0, 1, 0, 4'd11, 1));
`else
        expect_out("irq_te_ignored", op_e(0, 1, 0, 4'd4, 0));
        tick(); clr(); expect_out("irq_te_idle1", op_e(0, 1, 0, 4'd4, 0));
        tick(); expect_out("irq_te_idle2", op_e(0, 1, 0, 4'd4, 0));
`endif

        // global enable clear masks every source
        tick(); clr(); bus.meie_in = 1'b1; bus.e_irq_in = 1'b1; bus.mtie_in = 1'b1; bus.t_irq_in = 1'b1;
        bus.msie_in = 1'b1; bus.s_irq_in = 1'b1;
`ifdef MSRV32_IRQ_EN
        expect_out("irq_masked", op_e(0, 1, 0, 4'd11, 1));
`else
        expect_out("irq_masked", op_e(0, 1, 0, 4'd4, 0));
`endif

        // software + timer interrupt: software wins
        tick(); clr(); bus.mie_in = 1'b1; bus.msie_in = 1'b1; bus.s_irq_in = 1'b1;
        bus.mtie_in = 1'b1; bus.t_irq_in = 1'b1;
`ifdef MSRV32_IRQ_EN
        expect_out("irq_st_detect", op_e(1, 0, 0, 4'd11, 1));
        tick(); clr(); expect_out("irq_st_trap", tt_e(4'd3, 1));
        tick(); expect_out("irq_st_after", op_e(0, 1, 0, 4'd3, 1));
        c_after_irq = 4'd3; ioe_after_irq = 1'b1;
`else
        expect_out("irq_st_ignored", op_e(0, 1, 0, 4'd4, 0));
        tick(); clr(); expect_out("irq_st_idle1", op_e(0, 1, 0, 4'd4, 0));
        tick(); expect_out("irq_st_idle2", op_e(0, 1, 0, 4'd4, 0));
        c_after_irq = 4'd4; ioe_after_irq = 1'b0;
`endif

        // exception beats interrupt
        tick(); clr(); bus.illegal_instr_in = 1'b1; bus.mie_in = 1'b1; bus.meie_in = 1'b1; bus.e_irq_in = 1'b1;
        expect_out("exc_irq_detect", op_e(1, 0, 0, c_after_irq, ioe_after_irq));
        tick(); clr(); expect_out("exc_irq_trap", tt_e(4'd2, 0));
        tick(); expect_out("exc_irq_after", op_e(0, 1, 0, 4'd2, 0));

        // reset asserted during TRAP_TAKEN
        tick(); clr(); bus.misaligned_store_in = 1'b1;
        expect_out("rst_trap_detect", op_e(1, 0, 1, 4'd2, 0));
        tick(); clr(); rst = 1'b1; expect_out("rst_trap_taken", tt_e(4'd6, 0));
        tick(); rst = 1'b0; expect_out("rst_trap_reset", rs_e());
        tick(); expect_out("rst_trap_operating", op_e(0, 1, 0, 4'd0, 0));

        // let the monitor drain the queue, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msrv32_machine_control.md
# msrv32_machine_control

Trap and return sequencer for the MSRV32 core. Sits beside the instruction decoder and consumes its `illegal_instr_out`, `misaligned_load_out` and `misaligned_store_out` flags, plus the SYSTEM-instruction fields and interrupt lines. It drives `trap_taken_out` back into the decoder's `trap_taken_in` to suppress writes, and sequences the CSR cause/epc/mie updates, the PC source selection and pipeline flushes.

## Interface
- No parameters.
- `clk_in` input 1: core clock; all state changes on rising edge.
- `rst_in` input 1: synchronous, active-high reset.
- `illegal_instr_in` input 1: from decoder.
- `misaligned_load_in` input 1: from decoder.
- `misaligned_store_in` input 1: from decoder.
- `misaligned_instr_in` input 1: fetch target not 4-byte aligned.
- `opcode_6_to_2_in` input 5: instruction bits [6:2].
- `funct3_in` input 3: instruction bits [14:12].
- `funct7_in` input 7: instruction bits [31:25].
- `rs1_addr_in`, `rs2_addr_in`, `rd_addr_in` input 5 each: instruction register fields.
- `mie_in` input 1: mstatus.MIE.
- `meie_in`, `mtie_in`, `msie_in` input 1 each: mie enable bits.
- `e_irq_in`, `t_irq_in`, `s_irq_in` input 1 each: level interrupt requests.
- `trap_taken_out` output 1: trap detected this cycle; goes to decoder `trap_taken_in`.
- `i_or_e_out` output 1: 1 = interrupt, 0 = exception (mcause[31]).
- `cause_out` output 4: mcause code.
- `set_cause_out`, `set_epc_out`, `mie_clear_out`, `mie_set_out` output 1 each: CSR write strobes.
- `instret_inc_out` output 1: retire-counter increment.
- `misaligned_exception_out` output 1: selects faulting address for mtval.
- `pc_src_out` output 2: 00 boot, 01 mepc, 10 trap vector, 11 next PC.
- `flush_out` output 1: kill instruction in flight.

## Operation
- States: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN. Encoding is free; the state is one register.
- Decode (SYSTEM = opcode 5'b11100, funct3 000, rs1 = 0, rd = 0):
  - ecall: funct7 = 0, rs2 = 0.
  - ebreak: funct7 = 0, rs2 = 1.
  - mret: funct7 = 7'b0011000, rs2 = 5'b00010.
- `exc` = misaligned_instr | illegal | ebreak | misaligned_load | misaligned_store | ecall.
- `irq` = mie_in & ((meie & e_irq) | (mtie & t_irq) | (msie & s_irq)).
- Exception cause priority, high to low: misaligned_instr 0, illegal 2, ebreak 3, misaligned_load 4, misaligned_store 6, ecall 11.
- Interrupt cause priority: external 11, software 3, timer 7.
- `exc` beats `irq`. Either one beats mret.
- Transitions:
  - RESET → OPERATING when rst_in = 0.
  - OPERATING → TRAP_TAKEN on exc | irq.
  - OPERATING → TRAP_RETURN on mret with no exc/irq.
  - Otherwise OPERATING holds.
  - TRAP_TAKEN → OPERATING and TRAP_RETURN → OPERATING, unconditionally.
  - rst_in = 1 forces RESET from any state.
- Cause and i_or_e are registered on the OPERATING → TRAP_TAKEN edge. They hold until the next trap entry.
- Outputs per state:
  - RESET: pc_src 00, flush 1, all strobes 0.
  - OPERATING: pc_src 11, flush 0.
    - trap_taken_out = exc | irq (combinational).
    - instret_inc_out = ~(exc | irq | mret).
    - misaligned_exception_out = misaligned_instr | misaligned_load | misaligned_store.
  - TRAP_TAKEN: pc_src 10, flush 1, set_cause 1, set_epc 1, mie_clear 1.
  - TRAP_RETURN: pc_src 01, flush 1, mie_set 1.
- IRQ lines are level-sensitive and not latched. They are ignored in RESET, TRAP_TAKEN and TRAP_RETURN, and re-evaluated on return to OPERATING.

## Timing
- Reset values: cause_out 0, i_or_e_out 0. All other outputs take their RESET-state values in the cycle after rst_in is sampled high.
- Cycle N, OPERATING, trap condition: trap_taken_out = 1 combinationally in N, so decoder write enables are gated in the same cycle.
- N+1, TRAP_TAKEN: CSR strobes, flush and pc_src 10 asserted for exactly one cycle. cause_out is valid.
- N+2: OPERATING.
- mret in cycle N: TRAP_RETURN in N+1 for one cycle, OPERATING in N+2. instret_inc_out = 0 in N.
- Back-to-back: a trap condition present in the first OPERATING cycle after a trap re-enters TRAP_TAKEN. The minimum trap spacing is 2 cycles.
- rst_in asserted during TRAP_TAKEN or TRAP_RETURN: state is RESET next cycle. No further strobes; cause_out clears.
- Release from reset: first OPERATING cycle is the cycle after rst_in is sampled low.

## Configuration
- `MSRV32_IRQ_EN` defined: interrupt detection, interrupt cause encoding and i_or_e_out = 1 path compiled in.
- `MSRV32_IRQ_EN` undefined:
  - `irq` is constant 0.
  - All irq and enable inputs are ignored but remain as ports.
  - i_or_e_out is tied to 0.
  - Exception and mret behaviour are unchanged.

## Test plan
- Reset: hold rst_in 3 cycles, then release → pc_src 00 and flush 1 during reset; cause_out 0; pc_src 11 and flush 0 from the first cycle after release.
- illegal_instr_in = 1 for one cycle → trap_taken_out = 1 that cycle. Next cycle: set_cause, set_epc, mie_clear, flush = 1, pc_src 10, cause_out 2, i_or_e_out 0. The cycle after: OPERATING.
- Simultaneous misaligned_load_in, misaligned_store_in and an ecall encoding → cause_out 4; misaligned_exception_out = 1 in the detect cycle.
- mret encoding (funct7 0x18, rs2 2) → next cycle pc_src 01, mie_set 1, flush 1; instret_inc_out 0 in the detect cycle.
- With `MSRV32_IRQ_EN` defined: mie_in = 1, mtie_in = 1, t_irq_in = 1 and also meie_in = 1, e_irq_in = 1 → cause_out 11, i_or_e_out 1. With the macro undefined, the same stimulus produces no trap.
- Assert rst_in during TRAP_TAKEN → next cycle RESET outputs, cause_out 0, no second set_cause pulse.
